// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - WIN x WIN pixel window generator with position tracking
//
// Purpose:
//   Assembles a WIN x WIN window of registered taps from WIN vertically
//   aligned row streams coming out of the line-buffer chain. It tracks the
//   column/row of each accepted column and flags windows that lie fully
//   inside the image, together with end-of-line and end-of-frame strobes.
//
// Parameters:
//   DW     pixel width in bits
//   WIN    window size (odd, 3..7)
//   IMG_W  active pixels per line
//   IMG_H  active lines per frame
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   shift_en   one pixel column accepted this cycle
//   sof        start of frame, qualified by shift_en; accepted column is (0,0)
//   col_din    incoming column, slice r (bits r*DW +: DW) is row r,
//              r=0 oldest line, r=WIN-1 live input
//   win        window taps, tap (r,c) at bits (r*WIN+c)*DW +: DW,
//              c=0 oldest (leftmost) column
//   win_valid  one-cycle pulse, win holds a fully interior window
//   win_eol    win_valid on the last column of a line
//   win_eof    win_eol on the last line of a frame
//   col_cnt    column index of the most recently accepted column
//   row_cnt    row index of the most recently accepted column
//
// Build option:
//   SOBEL_WIN_BORDER_REPLICATE_EN - when defined, the column accepted at
//   col 0 is replicated into every window column, and win_valid no longer
//   waits for WIN-1 columns of the new line.

module sobel_window_gen #(
  parameter int DW    = 8,
  parameter int WIN   = 3,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic                       sof,
  input  logic [WIN*DW-1:0]          col_din,
  output logic [WIN*WIN*DW-1:0]      win,
  output logic                       win_valid,
  output logic                       win_eol,
  output logic                       win_eof,
  output logic [$clog2(IMG_W)-1:0]   col_cnt,
  output logic [$clog2(IMG_H)-1:0]   row_cnt
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);
`ifndef SOBEL_WIN_BORDER_REPLICATE_EN
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
`endif

  // Set out of reset so the very first accepted column is treated as (0,0)
  // even if the source never raised sof.
  logic first_q;

  logic [CW-1:0]          pos_col;
  logic [RW-1:0]          pos_row;
  logic [WIN*WIN*DW-1:0]  win_nxt;
  logic                   valid_nxt;
  logic                   eol_nxt;
  logic                   eof_nxt;

  // Position of the column being accepted this cycle. Only meaningful when
  // shift_en is high; the register update below is gated accordingly.
  always_comb begin
    pos_col = col_cnt;
    pos_row = row_cnt;
    if (sof || first_q) begin
      pos_col = '0;
      pos_row = '0;
    end else if (col_cnt == COL_LAST) begin
      pos_col = '0;
      if (row_cnt == ROW_LAST) begin
        pos_row = '0;
      end else begin
        pos_row = row_cnt + RW'(1);
      end
    end else begin
      pos_col = col_cnt + CW'(1);
    end
  end

  // Tap shift: every row moves one column left and the new pixel enters at
  // the right. Columns from the previous line are deliberately kept; the
  // column condition on win_valid hides them until they have been flushed.
  always_comb begin
    win_nxt = win;
    if (shift_en) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_nxt[(r*WIN+c)*DW +: DW] = win[(r*WIN+c+1)*DW +: DW];
        end
        win_nxt[(r*WIN+WIN-1)*DW +: DW] = col_din[r*DW +: DW];
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
        if (pos_col == '0) begin
          for (int c = 0; c < WIN - 1; c++) begin
            win_nxt[(r*WIN+c)*DW +: DW] = col_din[r*DW +: DW];
          end
        end
`endif
      end
    end
  end

  // Strobes are evaluated on the position of the accepted column so they
  // line up with the taps that column produces.
  always_comb begin
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
    valid_nxt = shift_en && (pos_row >= ROW_MIN);
`else
    valid_nxt = shift_en && (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
`endif
    eol_nxt = valid_nxt && (pos_col == COL_LAST);
    eof_nxt = eol_nxt && (pos_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win       <= '0;
      win_valid <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      first_q   <= 1'b1;
    end else begin
      win       <= win_nxt;
      win_valid <= valid_nxt;
      win_eol   <= eol_nxt;
      win_eof   <= eof_nxt;
      if (shift_en) begin
        col_cnt <= pos_col;
        row_cnt <= pos_row;
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen

module tb_sobel_window_gen;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
`ifdef SOBEL_WIN_BORDER_REPLICATE_EN
  localparam int WIN   = 5;
  localparam bit REP   = 1'b1;
  localparam int EXP_VALID = 16;
  localparam int EXP_EOL   = 2;
  localparam int EXP_FV_COL = 0;
  localparam int EXP_FV_ROW = 4;
`else
  localparam int WIN   = 3;
  localparam bit REP   = 1'b0;
  localparam int EXP_VALID = 24;
  localparam int EXP_EOL   = 4;
  localparam int EXP_FV_COL = 2;
  localparam int EXP_FV_ROW = 2;
`endif
  localparam int CDW = WIN*DW;
  localparam int WW  = WIN*WIN*DW;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int NPIX = IMG_W*IMG_H;

  logic           clk;
  logic           rst;
  logic           shift_en;
  logic           sof;
  logic [CDW-1:0] col_din;
  logic [WW-1:0]  win;
  logic           win_valid;
  logic           win_eol;
  logic           win_eof;
  logic [CW-1:0]  col_cnt;
  logic [RW-1:0]  row_cnt;

  sobel_window_gen #(.DW(DW), .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .sof(sof), .col_din(col_din),
    .win(win), .win_valid(win_valid), .win_eol(win_eol), .win_eof(win_eof),
    .col_cnt(col_cnt), .row_cnt(row_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the last WIN accepted columns (oldest first) and a
  // linear pixel index within the frame.
  logic [CDW-1:0] hist[$];
  int  m_k, m_col, m_row;
  bit  m_started, m_valid, m_eol, m_eof;
  int  n_valid, n_eol, n_eof;

  logic [CDW-1:0] fdat [NPIX];
  logic [WW-1:0]  ew   [NPIX];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win();
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[(r*WIN+c)*DW +: DW] = hist[c][r*DW +: DW];
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < WIN; i++) hist.push_back('0);
    m_started = 1'b0;
    m_k = 0; m_col = 0; m_row = 0;
    m_valid = 1'b0; m_eol = 1'b0; m_eof = 1'b0;
  endtask

  task automatic model_shift(input bit s, input logic [CDW-1:0] d);
    if (s || !m_started) m_k = 0;
    else m_k = (m_k + 1) % NPIX;
    m_started = 1'b1;
    m_col = m_k % IMG_W;
    m_row = m_k / IMG_W;
    if (REP && m_col == 0) begin
      for (int i = 0; i < WIN; i++) hist[i] = d;
    end else begin
      void'(hist.pop_front());
      hist.push_back(d);
    end
    m_valid = (m_row >= WIN-1) && (REP || m_col >= WIN-1);
    m_eol   = m_valid && (m_col == IMG_W-1);
    m_eof   = m_eol && (m_row == IMG_H-1);
  endtask

  task automatic step(input bit r, input bit se, input bit s, input logic [CDW-1:0] d);
    rst = r; shift_en = se; sof = s; col_din = d;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (se) model_shift(s, d);
    else begin
      m_valid = 1'b0; m_eol = 1'b0; m_eof = 1'b0;
    end
    chk("win", 256'(win), 256'(model_win()));
    chk("win_valid", 256'(win_valid), 256'(m_valid));
    chk("win_eol", 256'(win_eol), 256'(m_eol));
    chk("win_eof", 256'(win_eof), 256'(m_eof));
    chk("col_cnt", 256'(col_cnt), 256'(m_col));
    chk("row_cnt", 256'(row_cnt), 256'(m_row));
    if (win_valid) n_valid++;
    if (win_eol)   n_eol++;
    if (win_eof)   n_eof++;
  endtask

  function automatic logic [CDW-1:0] rand_col();
    logic [CDW-1:0] d;
    for (int r = 0; r < WIN; r++) d[r*DW +: DW] = DW'($urandom_range(0, 255));
    return d;
  endfunction

  function automatic logic [CDW-1:0] pix_col(input int col);
    logic [CDW-1:0] d;
    for (int r = 0; r < WIN; r++) d[r*DW +: DW] = DW'(16*r + col);
    return d;
  endfunction

  initial begin
    logic [WW-1:0] held;
    bit found;
    int fc, fr;

    rst = 1'b1; shift_en = 1'b0; sof = 1'b0; col_din = '0;
    model_reset();

    // Reset with shift_en high and all-ones data
    step(1, 1, 0, {CDW{1'b1}});
    step(1, 1, 0, {CDW{1'b1}});
    chk("rst_win_zero", 256'(win), 256'(0));
    chk("rst_valid", 256'(win_valid), 256'(0));

    // First shift after release without sof reports (0,0); row r carries 16*r+col
    step(0, 1, 0, pix_col(0));
    chk("first_pos_col", 256'(col_cnt), 256'(0));
    chk("first_pos_row", 256'(row_cnt), 256'(0));
    step(0, 1, 0, pix_col(1));
    step(0, 1, 0, pix_col(2));
    chk("tap1_a", 256'(win[(1*WIN+WIN-3)*DW +: DW]), 256'(8'h10));
    chk("tap1_b", 256'(win[(1*WIN+WIN-2)*DW +: DW]), 256'(8'h11));
    chk("tap1_c", 256'(win[(1*WIN+WIN-1)*DW +: DW]), 256'(8'h12));

    // Hold for 5 idle cycles
    held = model_win();
    for (int i = 0; i < 5; i++) step(0, 0, 0, rand_col());
    chk("hold_win", 256'(win), 256'(held));

    // Full gap-free frame
    step(1, 0, 0, '0);
    n_valid = 0; n_eol = 0; n_eof = 0;
    for (int i = 0; i < NPIX; i++) begin
      fdat[i] = rand_col();
      step(0, 1, (i == 0), fdat[i]);
      ew[i] = model_win();
    end
    chk("eof_on_last", 256'(win_eof), 256'(1));
    chk("frame_valid_cnt", 256'(n_valid), 256'(EXP_VALID));
    chk("frame_eol_cnt", 256'(n_eol), 256'(EXP_EOL));
    chk("frame_eof_cnt", 256'(n_eof), 256'(1));
    step(0, 1, 0, rand_col());
    chk("wrap_col", 256'(col_cnt), 256'(0));
    chk("wrap_row", 256'(row_cnt), 256'(0));

    // Mid-frame sof once the counters sit at row 3, col 4
    step(0, 1, 1, rand_col());
    for (int i = 0; i < 3*IMG_W + 4; i++) step(0, 1, 0, rand_col());
    chk("pre_sof_col", 256'(col_cnt), 256'(4));
    chk("pre_sof_row", 256'(row_cnt), 256'(3));
    step(0, 1, 1, rand_col());
    chk("sof_col", 256'(col_cnt), 256'(0));
    chk("sof_row", 256'(row_cnt), 256'(0));
    chk("sof_valid", 256'(win_valid), 256'(0));
    found = 1'b0; fc = -1; fr = -1;
    for (int i = 0; i < 2*NPIX && !found; i++) begin
      step(0, 1, 0, rand_col());
      if (win_valid) begin
        found = 1'b1; fc = int'(col_cnt); fr = int'(row_cnt);
      end
    end
    chk("first_valid_seen", 256'(found), 256'(1));
    chk("first_valid_col", 256'(fc), 256'(EXP_FV_COL));
    chk("first_valid_row", 256'(fr), 256'(EXP_FV_ROW));

    // Same frame again with random idle gaps between shifts
    step(1, 0, 0, '0);
    n_valid = 0; n_eol = 0; n_eof = 0;
    for (int i = 0; i < NPIX; i++) begin
      repeat ($urandom_range(0, 3)) step(0, 0, 0, rand_col());
      step(0, 1, (i == 0), fdat[i]);
      chk("gap_win", 256'(win), 256'(ew[i]));
    end
    chk("gap_valid_cnt", 256'(n_valid), 256'(EXP_VALID));
    chk("gap_eol_cnt", 256'(n_eol), 256'(EXP_EOL));
    chk("gap_eof_cnt", 256'(n_eof), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Parametrised successor of the 3x3 Sobel tap array: builds a WIN x WIN pixel window from WIN vertically aligned row streams supplied by the line buffers.
- Tracks pixel column/row position and flags which windows lie fully inside the image.
- Sits between the line-buffer chain and the convolution kernels (Sobel 3x3, later 5x5 smoothing).
- All taps are registered, and window-valid, end-of-line and end-of-frame strobes are produced alongside them.

Parameters:
- DW, 8: pixel width in bits.
- WIN, 3: window size (odd, 3..7).
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- shift_en  in  1  one pixel column accepted this cycle (last line-buffer FIFO write enable).
- sof  in  1  start of frame; qualified by shift_en; marks the current column as col 0, row 0.
- col_din  in  WIN*DW  incoming column. Slice r (bits r*DW +: DW) is row r; r=0 is the oldest (top) line and r=WIN-1 is the live input.
- win  out  WIN*WIN*DW  window taps. Tap (r,c) is at bits (r*WIN+c)*DW +: DW; c=0 is the oldest (leftmost) column.
- win_valid  out  1  one-cycle pulse: win holds a fully interior window.
- win_eol  out  1  pulse with win_valid/shift result of last column of a line.
- win_eof  out  1  pulse for last column of last line.
- col_cnt  out  $clog2(IMG_W)  column index of the most recently accepted column.
- row_cnt  out  $clog2(IMG_H)  row index of the most recently accepted column.

Behaviour:
- Reset (rst high at a clk edge) clears:
  - all taps to 0;
  - win_valid, win_eol and win_eof to 0;
  - col_cnt and row_cnt to 0;
  - the internal "first pixel" flag, which is set to 1.
- Reset has priority over shift_en and sof; reset mid-frame discards the window and the position.
- Shift: on a clk edge with shift_en=1, for every r:
  - tap(r,c) takes tap(r,c+1) for c < WIN-1;
  - tap(r,WIN-1) takes col_din slice r.
  - With shift_en=0 all taps hold.
- Latency: col_din to tap(r,WIN-1) is 1 cycle; no combinational path from input to win.
- Position counters, updated only on shift_en (pos = position of the accepted column):
  - sof=1 or first-pixel flag set: pos=(0,0); first-pixel flag cleared.
  - Otherwise col advances. At col=IMG_W-1 it wraps to 0 and row advances.
  - At row=IMG_H-1 with col=IMG_W-1 it wraps to (0,0).
  - sof asserted mid-frame forces (0,0) regardless of the current count.
  - col_cnt/row_cnt register pos.
- Strobes (registered, same edge as the taps, high for exactly 1 cycle per qualifying shift):
  - win_valid = shift_en & (pos.col >= WIN-1) & (pos.row >= WIN-1).
  - win_eol = win_valid & (pos.col == IMG_W-1).
  - win_eof = win_eol & (pos.row == IMG_H-1).
  - All three are 0 on any cycle without shift_en.
- Window columns are never cleared between lines. Columns from the previous line remain in taps, and win_valid stays low until WIN columns of the new line are loaded.
- Back-to-back shift_en every cycle is supported at full rate; arbitrary gaps are allowed.

Optional Feature:
- Macro: SOBEL_WIN_BORDER_REPLICATE_EN.
- Defined (left-edge replicate):
  - On a shift with pos.col == 0, every column c of row r is loaded with col_din slice r.
  - win_valid drops the column condition: win_valid = shift_en & (pos.row >= WIN-1).
  - The window centre then lags the input column by (WIN-1)/2; the downstream kernel compensates.
- Undefined: plain shift at col 0, and the column condition (pos.col >= WIN-1) applies.
- win_eol and win_eof are derived from win_valid in both builds.

Test Plan (DW=8, WIN=3, IMG_W=8, IMG_H=6 unless stated):
- Reset: drive rst=1 for 2 cycles with shift_en=1 and col_din=all 0xFF.
  - Expect win all 0, win_valid=0, col_cnt=0, row_cnt=0.
  - Next shift after release reports pos (0,0).
- Shift/hold, row r carrying pixel 16*r+col:
  - After shifts for cols 0,1,2 of any row, tap(1,0..2) = 0x10,0x11,0x12.
  - Holding shift_en=0 for 5 cycles leaves win unchanged.
- Valid map: stream one full frame of 48 shifts.
  - win_valid pulses exactly 24 times: rows 2..5 x cols 2..7.
  - win_eol pulses 4 times; win_eof pulses once, on the 48th shift.
  - Counters return to (0,0) on the 49th shift.
- Mid-frame sof: at pos (3,4), assert sof with shift_en.
  - col_cnt=0, row_cnt=0, win_valid=0.
  - The first valid occurs at pos (2,2) of the new frame.
- Gapped input: insert random 0-3 idle cycles between shifts over a full frame.
  - Tap contents and strobe count are identical to the gap-free run.
- Macro defined, WIN=5:
  - The shift at col 0 loads all 5 columns of each row with that column's pixel.
  - win_valid pulses at rows 4..5 for all 8 cols: 16 pulses.
